// File: rtl/jk_drv_pkg.sv
// Shared types for the JK register driver: FSM states and per-bit excitation codes.
// Latency: none (types and a pure combinational helper only).
// Backpressure: not applicable.
package jk_drv_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_ERR
    } state_t;

    // Excitation code is packed as {j, k}
    typedef enum logic [1:0] {
        EXC_HOLD   = 2'b00,
        EXC_RESET  = 2'b01,
        EXC_SET    = 2'b10,
        EXC_TOGGLE = 2'b11
    } exc_t;

    // Choose the JK input pair that moves the current bit q to target.
    function automatic exc_t exc_code(input logic q, input logic target, input logic use_toggle);
        exc_t code;
        code = EXC_HOLD;
        if (q != target) begin
            if (use_toggle)
                code = EXC_TOGGLE;
            else if (target)
                code = EXC_SET;
            else
                code = EXC_RESET;
        end
        return code;
    endfunction

endpackage

// File: rtl/jk_excite_bit.sv
// Single-bit JK excitation: maps current Q and desired value to a J/K pair.
// Latency: purely combinational.
// Backpressure: not applicable.
module jk_excite_bit
    import jk_drv_pkg::*;
(
    input  logic q,
    input  logic target,
    input  logic use_toggle,
    output logic j,
    output logic k
);

    exc_t code;

    // Look up the excitation code for this bit
    always_comb begin
        code = exc_code(q, target, use_toggle);
    end

    assign j = code[1];
    assign k = code[0];

endmodule

// File: rtl/jk_register_driver.sv
// Drives an external JK register to a requested word, reads it back and re-drives on mismatch.
// Latency: transfer to done pulse is 3 cycles with changing bits, 2 cycles when nothing differs.
// Backpressure: tgt_ready is high only in IDLE; a failed verify after all retries parks in ERR until err_clr.
module jk_register_driver
    import jk_drv_pkg::*;
#(
    parameter int WIDTH      = 4,
    parameter int MAX_RETRY  = 2,
    parameter int USE_TOGGLE = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tgt_valid,
    output logic             tgt_ready,
    input  logic [WIDTH-1:0] tgt_data,
    input  logic [WIDTH-1:0] q_fb,
    output logic [WIDTH-1:0] j,
    output logic [WIDTH-1:0] k,
    output logic             done,
    output logic             error,
    input  logic             err_clr
);

    localparam int RW = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] tgt_q, tgt_nxt;
    logic [WIDTH-1:0] j_q, j_nxt;
    logic [WIDTH-1:0] k_q, k_nxt;
    logic [RW-1:0]    retry_q, retry_nxt;
    logic             done_q, done_nxt;

    logic [WIDTH-1:0] exc_tgt;
    logic [WIDTH-1:0] exc_j;
    logic [WIDTH-1:0] exc_k;
    logic             transfer;
    logic             match;

    assign tgt_ready = (state == ST_IDLE);
    assign transfer  = tgt_valid && tgt_ready;
    assign match     = (q_fb == tgt_q);

    // In IDLE the excitation is computed against the word being offered so the
    // first drive can start on the transfer edge; afterwards against the latched target.
    assign exc_tgt = (state == ST_IDLE) ? tgt_data : tgt_q;

    for (genvar b = 0; b < WIDTH; b++) begin : g_excite
        jk_excite_bit u_excite (
            .q          (q_fb[b]),
            .target     (exc_tgt[b]),
            .use_toggle (USE_TOGGLE != 0),
            .j          (exc_j[b]),
            .k          (exc_k[b])
        );
    end

    // Next-state and next-output logic; j/k default to zero so they are only live in DRIVE
    always_comb begin
        state_nxt = state;
        tgt_nxt   = tgt_q;
        retry_nxt = retry_q;
        j_nxt     = '0;
        k_nxt     = '0;
        done_nxt  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (transfer) begin
                    tgt_nxt   = tgt_data;
                    retry_nxt = '0;
                    if ((q_fb ^ tgt_data) != '0) begin
                        state_nxt = ST_DRIVE;
                        j_nxt     = exc_j;
                        k_nxt     = exc_k;
                    end else begin
                        state_nxt = ST_SETTLE;
                    end
                end
            end
            ST_DRIVE:  state_nxt = ST_SETTLE;
            ST_SETTLE: state_nxt = ST_CHECK;
            ST_CHECK: begin
                if (match) begin
                    state_nxt = ST_IDLE;
                    done_nxt  = 1'b1;
                end else if (retry_q < RETRY_LIMIT) begin
                    state_nxt = ST_DRIVE;
                    retry_nxt = retry_q + RW'(1);
                    j_nxt     = exc_j;
                    k_nxt     = exc_k;
                end else begin
                    state_nxt = ST_ERR;
                end
            end
            ST_ERR: begin
                if (err_clr)
                    state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // State and registered outputs; reset clears j/k immediately so a drive cannot linger
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            tgt_q   <= '0;
            j_q     <= '0;
            k_q     <= '0;
            retry_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state   <= state_nxt;
            tgt_q   <= tgt_nxt;
            j_q     <= j_nxt;
            k_q     <= k_nxt;
            retry_q <= retry_nxt;
            done_q  <= done_nxt;
        end
    end

    assign j     = j_q;
    assign k     = k_q;
    assign done  = done_q;
    assign error = (state == ST_ERR);

endmodule

// File: doc/jk_register_driver.md
JK_REGISTER_DRIVER -- requirements
Module: jk_register_driver

Interface
REQ-001 SHALL have parameter WIDTH, default 4: bit count of the driven JK register.
REQ-002 SHALL have parameter MAX_RETRY, default 2: re-drive attempts allowed after a failed readback.
REQ-003 SHALL have parameter USE_TOGGLE, default 0: when 1, changing bits are driven J=K=1 (toggle) instead of set/reset.
REQ-004 SHALL have port clk  in  1  single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port tgt_valid  in  1  target word offered.
REQ-007 SHALL have port tgt_ready  out  1  driver can accept a target.
REQ-008 SHALL have port tgt_data  in  WIDTH  desired register contents.
REQ-009 SHALL have port q_fb  in  WIDTH  Q outputs read back from the external JK register.
REQ-010 SHALL have ports j and k  out  WIDTH each  registered excitation inputs to the external JK register.
REQ-011 SHALL have port done  out  1  one-cycle pulse: register verified equal to target.
REQ-012 SHALL have port error  out  1  sticky: retries exhausted.
REQ-013 SHALL have port err_clr  in  1  clears error and returns to IDLE.

Function
REQ-014 SHALL implement states IDLE, DRIVE, SETTLE, CHECK, ERR.
REQ-015 tgt_ready SHALL be 1 only in IDLE; transfer = tgt_valid && tgt_ready at a rising edge, capturing tgt_data into an internal target register.
REQ-016 On transfer, SHALL compute per-bit excitation from q_fb vs target: equal -> J=0,K=0; 0->1 -> J=1,K=0; 1->0 -> J=0,K=1; with USE_TOGGLE=1 any differing bit -> J=1,K=1.
REQ-017 j/k SHALL be nonzero only during DRIVE (exactly one cycle per attempt) and SHALL be all zero in every other state.
REQ-018 If no bits differ at transfer, SHALL skip DRIVE and go IDLE -> SETTLE.
REQ-019 SETTLE SHALL last one cycle (external register samples j/k at the DRIVE->SETTLE edge); CHECK SHALL compare q_fb to the target register.
REQ-020 CHECK match SHALL go IDLE with done=1 for exactly the following cycle; tgt_ready is 1 in that same cycle.
REQ-021 CHECK mismatch with retry count < MAX_RETRY SHALL increment the count, recompute excitation from current q_fb, and go DRIVE.
REQ-022 CHECK mismatch with retry count == MAX_RETRY SHALL go ERR and set error=1.
REQ-023 ERR SHALL hold j=k=0, tgt_ready=0, and error=1 until err_clr=1 at a rising edge, then go IDLE with error=0.
REQ-024 err_clr outside ERR SHALL have no effect; the retry count SHALL clear on every transfer.
REQ-025 Nominal latency: transfer edge to done pulse = 3 cycles with changes, 2 cycles with none.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, j=0, k=0, done=0, error=0, retry count=0, target register=0, tgt_ready=1 after release.
REQ-027 Reset mid-DRIVE SHALL drop j/k to zero asynchronously; no partial attempt SHALL resume after release.

Structure
REQ-028 Package jk_drv_pkg SHALL hold the state enum and the 2-bit excitation codes (HOLD=00, RESET=01, SET=10, TOGGLE=11).
REQ-029 Per-bit excitation SHALL be a combinational sub-module jk_excite_bit (inputs q, target, use_toggle; outputs j, k), instantiated WIDTH times.

Verification (WIDTH=4, bench includes a behavioral 4-bit JK register fed by j/k and driving q_fb)
REQ-030 Register=0000, target 1010 -> DRIVE cycle j=1010,k=0000; done pulses 3 cycles after transfer; q_fb=1010.
REQ-031 Register=1010, target 0110, USE_TOGGLE=1 -> j=1100,k=1100; done after 3 cycles; q_fb=0110.
REQ-032 Target equal to current 0110 -> no DRIVE (j=k=0 throughout); done 2 cycles after transfer.
REQ-033 Bench forces bit0 stuck at 0, target 0001 -> exactly 3 DRIVE cycles (1 + MAX_RETRY) then error=1; err_clr -> IDLE, error=0.
REQ-034 rst_n asserted during DRIVE -> j=k=0 without waiting for a clock edge; after release tgt_ready=1, done=0, error=0.
REQ-035 tgt_valid held high across back-to-back targets 0011, 1100 -> second accepted in the done cycle; both verified in order.
